lc3_data_mem: RTL

- Synthesizable data-memory slave sitting directly downstream of the LC3 MemAccess stage.
- Consumes `Data_addr`, `Data_din` and `Data_rd` from the core; returns `Data_dout` and the `complete_data` handshake.
- Models a fixed, parameterisable access latency so that controller memory stalls (`mem_state`) are exercised.
- Includes a backdoor load port so the bench can preload data before the core runs.

---
 rtl/lc3_data_mem.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lc3_data_mem.sv
// LC3 data-memory slave with fixed access latency, backdoor load port
// and saturating read/write completion counters.
module lc3_data_mem #(
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] INIT_VAL  = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Data_req,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    input  logic        Data_rd,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    output logic        busy,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "lc3_data_mem: LATENCY must be in 1..15");
    end

    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [ADDR_BITS-1:0] addr_q;
    logic [15:0]          din_q;
    logic                 rd_q;

    logic [ADDR_BITS-1:0] acc_addr;
    logic [ADDR_BITS-1:0] ld_addr;
    logic [15:0]          acc_din;
    logic                 acc_rd;
    logic [15:0]          rd_val;
    logic                 capture;
    logic                 commit;

    logic [15:0] dout_q;
    logic        complete_q;
    logic        busy_q;
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    logic [15:0] mem [DEPTH];

    logic unused_hi;
    assign unused_hi = ^{Data_addr[15:ADDR_BITS], load_addr[15:ADDR_BITS]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Data_req) begin
                    capture = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the access completes on its capture edge, so the
    // live inputs stand in for the not-yet-latched request registers.
    always_comb begin
        acc_addr = addr_q;
        acc_din  = din_q;
        acc_rd   = rd_q;
        if (state_q == IDLE) begin
            acc_addr = Data_addr[ADDR_BITS-1:0];
            acc_din  = Data_din;
            acc_rd   = Data_rd;
        end
    end

    assign ld_addr = load_addr[ADDR_BITS-1:0];
    assign commit  = reset && (state_d == DONE) && (state_q != DONE);
    assign rd_val  = (load_en && ld_addr == acc_addr) ? load_data
                                                      : mem[acc_addr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            din_q      <= 16'h0000;
            rd_q       <= 1'b1;
            dout_q     <= INIT_VAL;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            rd_cnt_q   <= 16'h0000;
            wr_cnt_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d != IDLE);
            complete_q <= commit;
            if (capture) begin
                addr_q <= Data_addr[ADDR_BITS-1:0];
                din_q  <= Data_din;
                rd_q   <= Data_rd;
            end
            if (commit) begin
                if (acc_rd == 1'b0) begin
                    if (wr_cnt_q != 16'hFFFF) begin
                        wr_cnt_q <= wr_cnt_q + 16'd1;
                    end
                end else begin
                    dout_q <= rd_val;
                    if (rd_cnt_q != 16'hFFFF) begin
                        rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    // Core write is ordered after the backdoor load so it wins a tie.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[ld_addr] <= load_data;
        end
        if (commit && acc_rd == 1'b0) begin
            mem[acc_addr] <= acc_din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && capture) begin
            assert (!$isunknown(Data_rd));
        end
    end

    assign Data_dout     = dout_q;
    assign complete_data = complete_q;
    assign busy          = busy_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule
